// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for param_regfile.
//   state_t          - controller state (INIT = clearing sweep, RUN = normal operation)
//   DEFAULT_DATA_W   - default register width
//   DEFAULT_ADDR_W   - default register address width
//   DEFAULT_NUM_RD   - default number of read ports
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 3;
    localparam int DEFAULT_NUM_RD = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/param_regfile.sv
// param_regfile: parameterised register file with a post-reset clearing sweep,
// hard-wired zero register and NUM_RD independent combinational read ports.
//
// Ports:
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous active-high reset
//   RegWrite   in   1              write request this cycle
//   writereg   in   ADDR_W         write address
//   writedata  in   DATA_W         write data
//   readreg    in   NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   readdata   out  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
//   ready      out  1              sweep finished, writes accepted
//   wr_drop    out  1              a write request was discarded last cycle
//
// Build option: define PARAM_REGFILE_BYPASS_EN to forward same-cycle write
// data to matching read ports. Default build has no bypass path.
module param_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = DEFAULT_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        writereg,
    input  logic [DATA_W-1:0]        writedata,
    input  logic [NUM_RD*ADDR_W-1:0] readreg,
    output logic [NUM_RD*DATA_W-1:0] readdata,
    output logic                     ready,
    output logic                     wr_drop
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    // Controller, sweep and write port. The array itself is not reset: the
    // sweep clears every entry before RUN, and reads are forced to 0 until then.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
            wr_drop <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    mem[clr_cnt] <= '0;
                    clr_cnt      <= clr_cnt + 1'b1;
                    // Any request during the sweep is discarded and flagged.
                    wr_drop      <= RegWrite;
                    if (clr_cnt == LAST) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    wr_drop <= 1'b0;
                    // Writes to entry 0 are a silent no-op, not a drop.
                    if (RegWrite && (writereg != '0)) begin
                        mem[writereg] <= writedata;
                    end
                end
            endcase
        end
    end

    assign ready = (state == ST_RUN);

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = readreg[i*ADDR_W +: ADDR_W];

        always_comb begin
            data = '0;
            if ((state == ST_RUN) && (addr != '0)) begin
                data = mem[addr];
`ifdef PARAM_REGFILE_BYPASS_EN
                if (RegWrite && (writereg != '0) && (writereg == addr)) begin
                    data = writedata;
                end
`endif
            end
        end

        assign readdata[i*DATA_W +: DATA_W] = data;
    end

endmodule

// File: tb/tb_param_regfile.sv
// tb_param_regfile: self-checking bench for param_regfile (default parameters).
// Expected read data comes from a bench-side register model; values are pushed
// to a scoreboard queue when addresses are driven and popped when sampled.
module tb_param_regfile;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     RegWrite;
    logic [ADDR_W-1:0]        writereg;
    logic [DATA_W-1:0]        writedata;
    logic [NUM_RD*ADDR_W-1:0] readreg;
    logic [NUM_RD*DATA_W-1:0] readdata;
    logic                     ready;
    logic                     wr_drop;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] sb [$];

    always #5 clk = ~clk;

    param_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RegWrite  (RegWrite),
        .writereg  (writereg),
        .writedata (writedata),
        .readreg   (readreg),
        .readdata  (readdata),
        .ready     (ready),
        .wr_drop   (wr_drop)
    );

    // Advance past the next rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
    endtask

    // Single write transaction; model updated only when the bench knows RUN holds.
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit in_run);
        RegWrite  = 1'b1;
        writereg  = a;
        writedata = d;
        tick();
        RegWrite  = 1'b0;
        if (in_run && a != '0) model[a] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; RegWrite = 1'b0; writereg = '0; writedata = '0; readreg = '0;
        tick();
        rst = 1'b0;
        clear_model();
        for (int c = 0; c < DEPTH; c++) begin
            readreg = {ADDR_W'(c), ADDR_W'(DEPTH - 1 - c)};
            for (int p = 0; p < NUM_RD; p++) sb.push_back('0);
            #2;
            n_checks++;
            if (ready !== 1'b0) $display("FAIL init_ready c=%0d: got %b expected 0", c, ready);
            else n_pass++;
            for (int p = 0; p < NUM_RD; p++) begin
                logic [DATA_W-1:0] e;
                e = sb.pop_front();
                n_checks++;
                if (readdata[p*DATA_W +: DATA_W] !== e)
                    $display("FAIL init_read c=%0d p=%0d: got %h expected %h", c, p, readdata[p*DATA_W +: DATA_W], e);
                else n_pass++;
            end
            tick();
        end
        #2;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL ready_after_sweep: got %b expected 1", ready);
        else n_pass++;
        for (int a = 0; a < DEPTH; a++) begin
            readreg = {ADDR_W'(a), ADDR_W'(a)};
            sb.push_back(model[a]);
            #1;
            n_checks++;
            begin
                logic [DATA_W-1:0] e;
                e = sb.pop_front();
                if (readdata[0 +: DATA_W] !== e || readdata[DATA_W +: DATA_W] !== e)
                    $display("FAIL run_clear_read a=%0d: got %h/%h expected %h", a,
                             readdata[0 +: DATA_W], readdata[DATA_W +: DATA_W], e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_write_read();
        wr(3'd3, 16'hBEEF, 1'b1);
        readreg = {3'd3, 3'd3};
        sb.push_back(model[3]);
        sb.push_back(16'hBEEF);
        #2;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [DATA_W-1:0] e;
            e = sb.pop_front();
            n_checks++;
            if (readdata[p*DATA_W +: DATA_W] !== e)
                $display("FAIL write_read p=%0d: got %h expected %h", p, readdata[p*DATA_W +: DATA_W], e);
            else n_pass++;
        end
        n_checks++;
        if (wr_drop !== 1'b0) $display("FAIL write_read_drop: got %b expected 0", wr_drop);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        wr(3'd0, 16'h1234, 1'b1);
        readreg = {3'd0, 3'd0};
        sb.push_back('0);
        sb.push_back('0);
        #2;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [DATA_W-1:0] e;
            e = sb.pop_front();
            n_checks++;
            if (readdata[p*DATA_W +: DATA_W] !== e)
                $display("FAIL zero_reg p=%0d: got %h expected %h", p, readdata[p*DATA_W +: DATA_W], e);
            else n_pass++;
        end
        n_checks++;
        if (wr_drop !== 1'b0) $display("FAIL zero_reg_drop: got %b expected 0", wr_drop);
        else n_pass++;
    endtask

    task automatic test_init_write();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        tick();
        tick();                        // now in sweep cycle 2
        wr(3'd5, 16'hAAAA, 1'b0);
        #2;
        n_checks++;
        if (wr_drop !== 1'b1) $display("FAIL init_drop_pulse: got %b expected 1", wr_drop);
        else n_pass++;
        tick();
        #2;
        n_checks++;
        if (wr_drop !== 1'b0) $display("FAIL init_drop_clear: got %b expected 0", wr_drop);
        else n_pass++;
        n_checks++;
        if (ready !== 1'b0) $display("FAIL init_ready_low: got %b expected 0", ready);
        else n_pass++;
        // 4 sweep cycles consumed so far; 4 remain before RUN.
        for (int c = 0; c < DEPTH - 4; c++) tick();
        #2;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL init_ready_high: got %b expected 1", ready);
        else n_pass++;
        readreg = {3'd5, 3'd3};
        sb.push_back(model[3]);
        sb.push_back(model[5]);
        #1;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [DATA_W-1:0] e;
            e = sb.pop_front();
            n_checks++;
            if (readdata[p*DATA_W +: DATA_W] !== e)
                $display("FAIL init_write_read p=%0d: got %h expected %h", p, readdata[p*DATA_W +: DATA_W], e);
            else n_pass++;
        end
    endtask

    task automatic test_same_cycle();
        logic [DATA_W-1:0] e_now;
        wr(3'd2, 16'h0001, 1'b1);
`ifdef PARAM_REGFILE_BYPASS_EN
        e_now = 16'h00FF;
`else
        e_now = model[2];
`endif
        RegWrite = 1'b1; writereg = 3'd2; writedata = 16'h00FF;
        readreg = {3'd2, 3'd2};
        sb.push_back(e_now);
        sb.push_back(e_now);
        #2;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [DATA_W-1:0] e;
            e = sb.pop_front();
            n_checks++;
            if (readdata[p*DATA_W +: DATA_W] !== e)
                $display("FAIL same_cycle p=%0d: got %h expected %h", p, readdata[p*DATA_W +: DATA_W], e);
            else n_pass++;
        end
        tick();
        RegWrite = 1'b0;
        model[2] = 16'h00FF;
        sb.push_back(model[2]);
        #2;
        begin
            logic [DATA_W-1:0] e;
            e = sb.pop_front();
            n_checks++;
            if (readdata[0 +: DATA_W] !== e)
                $display("FAIL same_cycle_next: got %h expected %h", readdata[0 +: DATA_W], e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        int waited;
        wr(3'd4, 16'h5555, 1'b1);
        readreg = {3'd4, 3'd4};
        sb.push_back(model[4]);
        #2;
        begin
            logic [DATA_W-1:0] e;
            e = sb.pop_front();
            n_checks++;
            if (readdata[DATA_W +: DATA_W] !== e)
                $display("FAIL mid_run_pre: got %h expected %h", readdata[DATA_W +: DATA_W], e);
            else n_pass++;
        end
        // Hold reset across several edges: sweep must not advance meanwhile.
        rst = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        rst = 1'b0;
        clear_model();
        #2;
        n_checks++;
        if (ready !== 1'b0) $display("FAIL mid_run_ready_drop: got %b expected 0", ready);
        else n_pass++;
        waited = 0;
        while (ready !== 1'b1 && waited < 4 * DEPTH) begin
            tick();
            waited++;
            #2;
        end
        n_checks++;
        if (waited != DEPTH) $display("FAIL mid_run_sweep_len: got %0d expected %0d", waited, DEPTH);
        else n_pass++;
        for (int a = 1; a < DEPTH; a++) begin
            readreg = {ADDR_W'(a), 3'd4};
            sb.push_back(model[4]);
            sb.push_back(model[a]);
            #1;
            for (int p = 0; p < NUM_RD; p++) begin
                logic [DATA_W-1:0] e;
                e = sb.pop_front();
                n_checks++;
                if (readdata[p*DATA_W +: DATA_W] !== e)
                    $display("FAIL mid_run_clear a=%0d p=%0d: got %h expected %h", a, p, readdata[p*DATA_W +: DATA_W], e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 40; c++) begin
            logic [ADDR_W-1:0] wa;
            logic [DATA_W-1:0] wd;
            logic              we;
            we = 1'($urandom_range(0, 3) != 0);
            wa = ADDR_W'($urandom_range(0, DEPTH - 1));
            wd = DATA_W'($urandom);
            RegWrite = we; writereg = wa; writedata = wd;
            readreg = {ADDR_W'($urandom_range(0, DEPTH - 1)), ADDR_W'($urandom_range(0, DEPTH - 1))};
            for (int p = 0; p < NUM_RD; p++) begin
                logic [ADDR_W-1:0] ra;
                logic [DATA_W-1:0] e;
                ra = readreg[p*ADDR_W +: ADDR_W];
                e  = (ra == '0) ? '0 : model[ra];
`ifdef PARAM_REGFILE_BYPASS_EN
                if (we && wa != '0 && wa == ra) e = wd;
`endif
                sb.push_back(e);
            end
            #2;
            for (int p = 0; p < NUM_RD; p++) begin
                logic [DATA_W-1:0] e;
                e = sb.pop_front();
                n_checks++;
                if (readdata[p*DATA_W +: DATA_W] !== e)
                    $display("FAIL b2b c=%0d p=%0d: got %h expected %h", c, p, readdata[p*DATA_W +: DATA_W], e);
                else n_pass++;
            end
            tick();
            if (we && wa != '0) model[wa] = wd;
            #2;
            n_checks++;
            if (wr_drop !== 1'b0) $display("FAIL b2b_drop c=%0d: got %b expected 0", c, wr_drop);
            else n_pass++;
            #1;
        end
        RegWrite = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_same_cycle();
        test_back_to_back();
        test_init_write();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_regfile.md
PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port RegWrite  input  1  write request for the current cycle.
REQ-007 SHALL have port writereg  input  ADDR_W  write address.
REQ-008 SHALL have port writedata  input  DATA_W  write data.
REQ-009 SHALL have port readreg  input  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port readdata  output  NUM_RD*DATA_W  packed read data; port i at bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port ready  output  1  high when init sweep is done and writes are accepted.
REQ-012 SHALL have port wr_drop  output  1  registered pulse: a write request was discarded in the previous cycle.

Function
REQ-013 SHALL implement a two-state FSM: INIT (clearing) and RUN.
REQ-014 SHALL, in INIT, write 0 to entry clr_cnt each cycle, clr_cnt counting 0..DEPTH-1, one entry per cycle.
REQ-015 SHALL move INIT->RUN on the cycle clr_cnt == DEPTH-1 is written; init sweep takes exactly DEPTH cycles after reset deasserts.
REQ-016 SHALL drive ready = 1 only in RUN (registered state, no combinational path from inputs).
REQ-017 SHALL, in RUN, write writedata to entry writereg on the rising edge when RegWrite = 1 and writereg != 0.
REQ-018 SHALL ignore writes to entry 0; entry 0 SHALL always read 0.
REQ-019 SHALL, in INIT, discard any RegWrite request and assert wr_drop for one cycle on the following cycle.
REQ-020 SHALL NOT assert wr_drop for writes to entry 0 in RUN (architectural no-op, not a drop).
REQ-021 SHALL provide combinational reads: readdata port i = entry readreg port i, zero latency, all ports independent.
REQ-022 SHALL return 0 on every read port while in INIT, regardless of address.
REQ-023 SHALL allow all read ports to address the same entry simultaneously with identical results.
REQ-024 SHALL, on a same-cycle read and write of the same entry without bypass, return the pre-write value; new value visible next cycle.

Reset
REQ-025 SHALL, with rst = 1 on a rising edge, enter INIT, set clr_cnt = 0 and wr_drop = 0; ready = 0 from that edge.
REQ-026 SHALL restart the sweep from entry 0 if rst asserts mid-sweep or in RUN; no partially cleared state survives.
REQ-027 SHALL hold INIT with clr_cnt = 0 while rst stays high; the sweep advances only with rst low.

Configuration
REQ-028 SHALL honour macro PARAM_REGFILE_BYPASS_EN.
REQ-029 SHALL, with PARAM_REGFILE_BYPASS_EN defined, forward writedata to any read port whose address equals writereg when RegWrite = 1, state is RUN and writereg != 0 (same-cycle write-to-read).
REQ-030 SHALL, without PARAM_REGFILE_BYPASS_EN, contain no bypass logic and behave per REQ-024.

Structure
REQ-031 SHALL take FSM state encoding (INIT, RUN) and default widths from shared package regfile_pkg.
REQ-032 SHALL be a single module; no sub-module required, read ports produced by a generate loop.

Verification
REQ-033 Reset then idle: rst 1 cycle, DEPTH=8 -> ready low for exactly 8 cycles, high on 9th; all reads 0.
REQ-034 Write/read: in RUN write 0xBEEF to r3, next cycle readreg port0=3, port1=3 -> both 0xBEEF.
REQ-035 Zero register: write 0x1234 to r0 -> r0 reads 0, wr_drop stays 0.
REQ-036 Write during INIT: RegWrite=1, writereg=5, wdata=0xAAAA at sweep cycle 2 -> wr_drop high next cycle; r5 reads 0 after ready.
REQ-037 Same-cycle read/write of r2 (old 0x0001, new 0x00FF) -> 0x00FF with PARAM_REGFILE_BYPASS_EN, 0x0001 without; 0x00FF next cycle in both.
REQ-038 Reset mid-RUN: r4 = 0x5555, assert rst -> ready drops, after DEPTH cycles r4 reads 0.
